// File: rtl/mux16_pkg.sv
// mux16_pkg: shared state encoding and defaults for the 16:1 mux scan controller
package mux16_pkg;
  localparam int NCH = 16;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DWELL = 4;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD, DONE} state_t;
endpackage

// File: rtl/mux16_scan_ctrl_if.sv
// mux16_scan_ctrl_if: mux select/data and downstream valid/ready bundle
interface mux16_scan_ctrl_if
  import mux16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic start;
  logic [NCH-1:0] mask;
  logic [WIDTH-1:0] Salida;
  logic S3, S2, S1, S0;
  logic [WIDTH-1:0] dato;
  logic [3:0] canal;
  logic valido;
  logic listo;
  logic ocupado;
  logic fin;
  modport master (
    input start, mask, Salida, listo,
    output S3, S2, S1, S0, dato, canal, valido, ocupado, fin
  );
  modport slave (
    output start, mask, Salida, listo,
    input S3, S2, S1, S0, dato, canal, valido, ocupado, fin
  );
endinterface

// File: rtl/mux16_next_chan.sv
// mux16_next_chan: lowest enabled channel above cur (or at cur when incl)
module mux16_next_chan
  import mux16_pkg::*;
(
  input  logic [NCH-1:0] mask,
  input  logic [3:0]     cur,
  input  logic           incl,
  output logic [3:0]     nxt,
  output logic           found
);
  always_comb begin
    nxt = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--)
      if (mask[i] && (i > int'(cur) || (incl && i == int'(cur)))) begin
        nxt = 4'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl: walks enabled mux channels in ascending order, settling each select before capture
module mux16_scan_ctrl
  import mux16_pkg::*;
#(
  parameter int DWELL = DEF_DWELL,
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst,
  mux16_scan_ctrl_if.master bus
);
  state_t st, st_n;
  logic [3:0] sel, cnt, canal_q, nxt;
  logic [NCH-1:0] mask_q;
  logic [WIDTH-1:0] dato_q;
  logic valido_q, found, settled, idle;
  assign idle = st == IDLE;
  assign settled = st == SETTLE && cnt == 4'(DWELL - 1);
  // In IDLE the search looks at the live mask from channel 0 inclusive; otherwise strictly above the select
  mux16_next_chan u_next (
    .mask (idle ? bus.mask : mask_q),
    .cur  (idle ? 4'd0 : sel),
    .incl (idle),
    .nxt  (nxt),
    .found(found)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= st_n;
  always_comb begin
    st_n = st;
    case (st)
      IDLE:    st_n = bus.start ? (found ? SETTLE : DONE) : IDLE;
      SETTLE:  st_n = settled ? HOLD : SETTLE;
      HOLD:    st_n = bus.listo ? (found ? SETTLE : DONE) : HOLD;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel <= '0;
      cnt <= '0;
      mask_q <= '0;
      dato_q <= '0;
      canal_q <= '0;
      valido_q <= 1'b0;
    end else begin
      if (idle && bus.start) begin
        mask_q <= bus.mask;
        sel <= nxt;
      end
      if (st == SETTLE) cnt <= settled ? '0 : cnt + 4'd1;
      if (settled) begin
        dato_q <= bus.Salida;
        canal_q <= sel;
        valido_q <= 1'b1;
      end
      if (st == HOLD && bus.listo) begin
        valido_q <= 1'b0;
        if (found) sel <= nxt;
      end
    end
  assign {bus.S3, bus.S2, bus.S1, bus.S0} = sel;
  assign bus.dato = dato_q;
  assign bus.canal = canal_q;
  assign bus.valido = valido_q;
  assign bus.ocupado = st == SETTLE || st == HOLD;
  assign bus.fin = st == DONE;
endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// tb_mux16_scan_ctrl: table-driven scans plus hand sequences for hold, reset and ignored inputs
module tb_mux16_scan_ctrl;
  typedef struct {
    logic [15:0] mask;
    int n;
    int first;
  } scan_t;
  logic clk = 1'b0;
  logic rst;
  int ncmp = 0;
  int nerr = 0;
  int got_c [16];
  int got_d [16];
  scan_t scans [5];
  int exp_c [25] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                     0, 15, 0, 5, 10, 3, 6, 9, 12};
  int exp_d [25] = '{'h00, 'h01, 'hFF, 'hFE, 'hFD, 'hFC, 'h02, 'h03,
                     'h61, 'h62, 'h63, 'h90, 'h91, 'h92, 'h93, 'hF0,
                     'h00, 'hF0, 'h00, 'hFC, 'h63, 'hFE, 'h02, 'h62, 'h91};
  logic [7:0] muxv [16] = '{8'h00, 8'h01, 8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'h02, 8'h03,
                            8'h61, 8'h62, 8'h63, 8'h90, 8'h91, 8'h92, 8'h93, 8'hF0};
  mux16_scan_ctrl_if #(.WIDTH(8)) bus ();
  mux16_scan_ctrl #(.DWELL(4), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  // Stand-in for the 16:1 mux: combinational lookup on the current select
  assign bus.Salida = muxv[{bus.S3, bus.S2, bus.S1, bus.S0}];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic collect(output int nx, output int fv, output int nf);
    bit done = 0;
    nx = 0;
    fv = -1;
    nf = 0;
    for (int e = 0; e < 300 && !done; e++) begin
      if (bus.valido && fv < 0) fv = e;
      if (bus.valido && bus.listo) begin
        if (nx < 16) begin
          got_c[nx] = int'(bus.canal);
          got_d[nx] = int'(bus.dato);
        end
        nx++;
      end
      if (bus.fin) nf++;
      else if (nf > 0) done = 1;
      if (!done) step;
    end
    if (!done) chk("scan_timeout", 0, 1);
  endtask
  task automatic run_scan(input logic [15:0] m, output int nx, output int fv, output int nf);
    bus.mask = m;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    collect(nx, fv, nf);
  endtask
  function automatic int outs();
    return int'({bus.ocupado, bus.fin, bus.valido, bus.canal, bus.S3, bus.S2, bus.S1, bus.S0, bus.dato});
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int nx, fv, nf, p, seen, fins;
    scans = '{'{16'hFFFF, 16, 4}, '{16'h8001, 2, 4}, '{16'h0000, 0, -1},
              '{16'h0421, 3, 4}, '{16'h1248, 4, 4}};
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mask = '0;
    bus.listo = 1'b0;
    #1;
    chk("reset_outputs", outs(), 0);
    step;
    rst = 1'b0;
    step;
    chk("idle_outputs", outs(), 0);
    p = 0;
    for (int s = 0; s < 5; s++) begin
      bus.listo = 1'b1;
      run_scan(scans[s].mask, nx, fv, nf);
      chk($sformatf("s%0d n_xfer", s), nx, scans[s].n);
      chk($sformatf("s%0d first_valido", s), fv, scans[s].first);
      chk($sformatf("s%0d fin_count", s), nf, 1);
      for (int i = 0; i < scans[s].n; i++) begin
        chk($sformatf("s%0d canal[%0d]", s, i), got_c[i], exp_c[p + i]);
        chk($sformatf("s%0d dato[%0d]", s, i), got_d[i], exp_d[p + i]);
      end
      p += scans[s].n;
    end
    // Single channel held off by listo=0 for ten cycles
    bus.listo = 1'b0;
    bus.mask = 16'h4000;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    for (int k = 0; k < 20 && !bus.valido; k++) step;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("hold_stable[%0d]", k),
          int'({bus.valido, bus.canal, bus.dato, bus.S3, bus.S2, bus.S1, bus.S0}),
          int'({1'b1, 4'hE, 8'h93, 4'hE}));
      step;
    end
    bus.listo = 1'b1;
    step;
    chk("hold_xfer_valido", int'(bus.valido), 0);
    chk("hold_fin", int'(bus.fin), 1);
    step;
    chk("hold_fin_one_cycle", int'({bus.fin, bus.ocupado}), 0);
    // Asynchronous reset after the third transfer
    bus.mask = 16'hFFFF;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && seen < 3; k++) begin
      if (bus.valido) seen++;
      step;
    end
    chk("pre_rst_xfers", seen, 3);
    chk("pre_rst_busy", int'(bus.ocupado), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", outs(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fins = 0;
    for (int k = 0; k < 8; k++) begin
      fins += int'(bus.fin) + int'(bus.ocupado);
      step;
    end
    chk("no_fin_after_rst", fins, 0);
    run_scan(16'hFFFF, nx, fv, nf);
    chk("post_rst n_xfer", nx, 16);
    chk("post_rst first canal", got_c[0], 0);
    chk("post_rst first dato", got_d[0], 'h00);
    chk("post_rst last canal", got_c[15], 15);
    // start and mask changes during HOLD are ignored
    bus.listo = 1'b0;
    bus.mask = 16'h0421;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    for (int k = 0; k < 20 && !bus.valido; k++) step;
    bus.mask = 16'hFFFF;
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    bus.listo = 1'b1;
    collect(nx, fv, nf);
    chk("ignore n_xfer", nx, 3);
    chk("ignore fin_count", nf, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ignore canal[%0d]", i), got_c[i], exp_c[18 + i]);
      chk($sformatf("ignore dato[%0d]", i), got_d[i], exp_d[18 + i]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/mux16_scan_ctrl.md
MUX16_SCAN_CTRL -- requirements
Module: mux16_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 4: settle cycles between driving a select and sampling mux data; legal range 1..15.
REQ-002 Parameter WIDTH, default 8: data width; equals the 16:1 mux data width.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  one-cycle request to begin a scan.
REQ-006 Port mask  input  16  channel enables; bit n enables channel n (A=0 .. P=15).
REQ-007 Port Salida  input  WIDTH  data returned by the 16:1 mux for the current select.
REQ-008 Port S3, S2, S1, S0  output  1 each  mux select; {S3,S2,S1,S0} = current channel.
REQ-009 Port dato  output  WIDTH  captured channel data.
REQ-010 Port canal  output  4  channel index of dato.
REQ-011 Port valido  output  1  dato/canal valid to downstream.
REQ-012 Port listo  input  1  downstream ready.
REQ-013 Port ocupado  output  1  high while a scan is in progress.
REQ-014 Port fin  output  1  one-cycle pulse at scan completion.

Function
REQ-015 FSM states SHALL be IDLE, SETTLE, HOLD, DONE.
REQ-016 In IDLE, start=1 SHALL latch mask; later mask changes SHALL NOT affect the scan in progress.
REQ-017 If the latched mask is nonzero, the FSM SHALL enter SETTLE with select = lowest set bit; if it is zero, the FSM SHALL enter DONE.
REQ-018 SETTLE SHALL count DWELL edges; on the DWELL-th edge it SHALL capture Salida into dato, the select into canal, set valido=1, and enter HOLD.
REQ-019 First valido SHALL rise exactly DWELL edges after the edge that samples start.
REQ-020 In HOLD, dato, canal, valido and the select SHALL hold stable while listo=0.
REQ-021 A transfer SHALL occur on an edge with valido=1 and listo=1; on that edge valido SHALL clear.
REQ-022 On transfer, if a higher enabled channel exists, select SHALL move to the next set bit above canal and the FSM SHALL enter SETTLE; otherwise it SHALL enter DONE.
REQ-023 DONE SHALL last one cycle with fin=1, then return to IDLE.
REQ-024 ocupado SHALL be 1 in SETTLE and HOLD and 0 in IDLE and DONE.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 Channel 15 SHALL never wrap to channel 0 within one scan; each enabled channel SHALL be delivered exactly once per scan in ascending order.
REQ-027 DWELL=1 SHALL sample Salida one edge after the select changes.

Reset
REQ-028 rst=1 SHALL immediately force IDLE and S3..S0=0, dato=0, canal=0, valido=0, ocupado=0, fin=0, latched mask=0 and dwell counter=0, without waiting for clk.
REQ-029 Reset mid-scan SHALL abandon the scan with no fin pulse; the first start after rst deasserts SHALL start a fresh scan.

Structure
REQ-030 Package mux16_pkg SHALL hold the state encoding, channel count (16), default WIDTH (8) and default DWELL (4).
REQ-031 The next-enabled-channel search (mask, current index -> next index, found flag) SHALL be a combinational sub-module named mux16_next_chan.
REQ-032 The bench SHALL connect S3..S0 and Salida to the existing mux16_1_8b_struc.

Verification
Mux inputs for all scenarios: A..P = 00,01,FF,FE,FD,FC,02,03,61,62,63,90,91,92,93,F0 (hex).
REQ-033 mask=FFFF, listo=1, start pulse -> 16 transfers: canal 0..15; dato 00,01,FF,FE,FD,FC,02,03,61,62,63,90,91,92,93,F0; then one fin pulse.
REQ-034 mask=8001 -> transfers (canal 0, dato 00) then (canal 15, dato F0); first valido exactly 4 edges after start; fin after the second transfer.
REQ-035 mask=4000, listo=0 for 10 cycles -> valido=1, canal=14, dato=93 and select=1110 stable for all 10 cycles; transfer on the first edge with listo=1.
REQ-036 mask=0000, start -> DONE on the next edge with a one-cycle fin; valido stays 0.
REQ-037 mask=FFFF, rst asserted between clock edges after the 3rd transfer -> all outputs 0 before the next edge; no fin pulse; a new start then delivers canal 0 first.
REQ-038 start pulsed during HOLD, and mask changed mid-scan -> both ignored; the scan completes per the originally latched mask.
